// File: rtl/game_pkg.sv
// game_pkg
// Shared types and constants for the LED reaction game blocks.
//   slot_state_t : per-slot FSM state (IDLE, LIT, COOL)
//   LEVEL_W      : width of the difficulty level input
//   LIFE_W       : width of the per-slot life/cool tick counter
//   LIFE         : lit lifetime in ticks, indexed by level
package game_pkg;

  localparam int LEVEL_W = 2;
  localparam int LIFE_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    COOL = 2'd2
  } slot_state_t;

  localparam logic [LIFE_W-1:0] LIFE [4] = '{4'd8, 4'd6, 4'd4, 4'd3};

  function automatic logic [LIFE_W-1:0] life_for(input logic [LEVEL_W-1:0] level);
    return LIFE[level];
  endfunction

endpackage

// File: rtl/led_slot.sv
// led_slot
// One LED slot: switch synchroniser + rising-edge detect, IDLE/LIT/COOL FSM,
// and a shared life/cool tick counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : game running; low forces IDLE
//   tick       : one-cycle game tick from the top
//   spawn      : spawn request for this slot
//   sw         : raw player switch, asynchronous to clk
//   life_init  : lifetime (ticks) to load on spawn
//   lit        : registered LED drive
//   hit, miss  : registered one-cycle event flags
module led_slot
  import game_pkg::*;
#(
  parameter int COOL_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tick,
  input  logic              spawn,
  input  logic              sw,
  input  logic [LIFE_W-1:0] life_init,
  output logic              lit,
  output logic              hit,
  output logic              miss
);

  localparam logic [LIFE_W-1:0] COOL_INIT = LIFE_W'(COOL_TICKS);
  localparam logic [LIFE_W-1:0] ONE       = LIFE_W'(1);

  logic              sw_meta, sw_sync, sw_prev, press;
  slot_state_t       state, state_nxt;
  logic [LIFE_W-1:0] cnt, cnt_nxt;
  logic              hit_nxt, miss_nxt;

  // The synchroniser runs regardless of enable so a switch already held
  // when the game starts does not produce a phantom press later.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
      sw_prev <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
    end
  end

  assign press = sw_sync & ~sw_prev;

  // A press is checked before expiry, so a press landing on the expiry tick
  // scores a hit and no miss.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (spawn) begin
            state_nxt = LIT;
            cnt_nxt   = life_init;
          end
        end
        LIT: begin
          if (press) begin
            hit_nxt   = 1'b1;
            state_nxt = COOL;
            cnt_nxt   = COOL_INIT;
          end else if (tick) begin
            if (cnt == ONE) begin
              miss_nxt  = 1'b1;
              state_nxt = COOL;
              cnt_nxt   = COOL_INIT;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
        end
        COOL: begin
          if (tick) begin
            cnt_nxt = cnt - ONE;
            if (cnt == ONE) state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // lit is gated by enable so LEDs go dark on the same edge the slots are
  // forced idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hit   <= 1'b0;
      miss  <= 1'b0;
      lit   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hit   <= hit_nxt;
      miss  <= miss_nxt;
      lit   <= enable && (state == LIT);
    end
  end

endmodule

// File: rtl/led_slot_tracker.sv
// led_slot_tracker
// Lights LEDs on spawn requests for a level-dependent lifetime, scores player
// presses on lit LEDs as hits and unpressed expiries as misses.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : game running; low idles all slots and freezes counters
//   level       : difficulty level, selects lifetime at spawn
//   spawn       : per-slot spawn request
//   sw          : raw player switches
//   led         : slot lit
//   hit_pulse   : one-cycle pulse, at least one hit
//   miss_pulse  : one-cycle pulse, at least one miss
//   score       : saturating hit total
//   misses      : saturating miss total
module led_slot_tracker
  import game_pkg::*;
#(
  parameter int NUM_LED    = 18,
  parameter int TICK_DIV   = 500000,
  parameter int COOL_TICKS = 2,
  parameter int SCORE_W    = 16,
  parameter int MISS_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  input  logic [NUM_LED-1:0] spawn,
  input  logic [NUM_LED-1:0] sw,
  output logic [NUM_LED-1:0] led,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W   = $clog2(NUM_LED + 1);
  localparam int SSUM_W  = SCORE_W + 1;
  localparam int MSUM_W  = MISS_W + 1;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [LIFE_W-1:0]  life_init;
  logic [NUM_LED-1:0] hit_vec, miss_vec;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;
  logic [SSUM_W-1:0]  score_sum;
  logic [MSUM_W-1:0]  miss_sum;

  assign tick = enable && (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tick_cnt <= '0;
    else if (!enable || tick)   tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Lifetime is looked up from the live level; each slot latches it only
  // when it spawns, so level changes never disturb a lit slot.
  assign life_init = life_for(level);

  for (genvar g = 0; g < NUM_LED; g++) begin : g_slot
    led_slot #(
      .COOL_TICKS(COOL_TICKS)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .tick     (tick),
      .spawn    (spawn[g]),
      .sw       (sw[g]),
      .life_init(life_init),
      .lit      (led[g]),
      .hit      (hit_vec[g]),
      .miss     (miss_vec[g])
    );
  end

  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      hit_cnt  = hit_cnt  + CNT_W'(hit_vec[i]);
      miss_cnt = miss_cnt + CNT_W'(miss_vec[i]);
    end
  end

  // One extra bit holds the carry; a set carry means the total passed
  // all-ones and is clamped there.
  assign score_sum = {1'b0, score}  + SSUM_W'(hit_cnt);
  assign miss_sum  = {1'b0, misses} + MSUM_W'(miss_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      misses     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else if (enable) begin
      score      <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      misses     <= miss_sum[MISS_W]   ? '1 : miss_sum[MISS_W-1:0];
      hit_pulse  <= (hit_cnt  != '0);
      miss_pulse <= (miss_cnt != '0);
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_slot_tracker.sv
module tb_led_slot_tracker;

  localparam int NUM_LED    = 18;
  localparam int TICK_DIV   = 4;
  localparam int COOL_TICKS = 2;
  // Narrower score keeps the saturation run short; behaviour is width-generic.
  localparam int SCORE_W    = 12;
  localparam int MISS_W     = 8;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
  localparam int MISS_MAX   = (1 << MISS_W) - 1;
  localparam int OBS_W      = NUM_LED + 2 + SCORE_W + MISS_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         level = 2'd0;
  logic [NUM_LED-1:0] spawn = '0;
  logic [NUM_LED-1:0] sw = '0;
  logic [NUM_LED-1:0] led;
  logic               hit_pulse, miss_pulse;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;

  int total = 0;
  int bad   = 0;

  led_slot_tracker #(
    .NUM_LED   (NUM_LED),
    .TICK_DIV  (TICK_DIV),
    .COOL_TICKS(COOL_TICKS),
    .SCORE_W   (SCORE_W),
    .MISS_W    (MISS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .level     (level),
    .spawn     (spawn),
    .sw        (sw),
    .led       (led),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .score     (score),
    .misses    (misses)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: slots are described by absolute game-tick deadlines
  // (expiry tick, tick at which the slot is free again) rather than by
  // per-slot down-counters.
  // ---------------------------------------------------------------------------
  int                 life_tab [4] = '{8, 6, 4, 3};
  bit                 m_lit    [NUM_LED];
  int                 m_expire [NUM_LED];
  int                 m_free   [NUM_LED];
  bit [NUM_LED-1:0]   s1, s2, s3;       // sw as sampled 1, 2, 3 edges ago
  int                 phase, ticks, pend_hits, pend_misses;
  logic [NUM_LED-1:0] exp_led = '0;
  logic               exp_hit = 1'b0, exp_miss = 1'b0;
  int                 exp_score = 0, exp_misses = 0;

  task automatic model_clear();
    for (int i = 0; i < NUM_LED; i++) begin
      m_lit[i] = 1'b0; m_expire[i] = 0; m_free[i] = 0;
    end
    s1 = '0; s2 = '0; s3 = '0;
    phase = 0; ticks = 0; pend_hits = 0; pend_misses = 0;
    exp_led = '0; exp_hit = 1'b0; exp_miss = 1'b0;
    exp_score = 0; exp_misses = 0;
  endtask

  task automatic model_step();
    bit               tick_now;
    int               t_after, nh, nm;
    bit [NUM_LED-1:0] press;
    for (int i = 0; i < NUM_LED; i++) exp_led[i] = m_lit[i] && enable;
    if (enable) begin
      exp_score  = (exp_score + pend_hits > SCORE_MAX) ? SCORE_MAX : exp_score + pend_hits;
      exp_misses = (exp_misses + pend_misses > MISS_MAX) ? MISS_MAX : exp_misses + pend_misses;
      exp_hit    = (pend_hits > 0);
      exp_miss   = (pend_misses > 0);
    end else begin
      exp_hit  = 1'b0;
      exp_miss = 1'b0;
    end
    // Switch seen two clocks late, counted only on a 0->1 change.
    press = s2 & ~s3;
    s3 = s2; s2 = s1; s1 = sw;
    tick_now = enable && (phase == TICK_DIV - 1);
    t_after  = ticks + (tick_now ? 1 : 0);
    nh = 0; nm = 0;
    for (int i = 0; i < NUM_LED; i++) begin
      if (!enable) begin
        m_lit[i] = 1'b0; m_free[i] = 0;
      end else if (m_lit[i]) begin
        if (press[i]) begin
          nh++; m_lit[i] = 1'b0; m_free[i] = t_after + COOL_TICKS;
        end else if (tick_now && t_after == m_expire[i]) begin
          nm++; m_lit[i] = 1'b0; m_free[i] = t_after + COOL_TICKS;
        end
      end else if (ticks >= m_free[i] && spawn[i]) begin
        m_lit[i] = 1'b1; m_expire[i] = t_after + life_tab[level];
      end
    end
    pend_hits = nh; pend_misses = nm;
    phase = enable ? (phase + 1) % TICK_DIV : 0;
    ticks = t_after;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) model_clear();
      else        model_step();
    end
  end

  function automatic logic [OBS_W-1:0] obs();
    return {led, hit_pulse, miss_pulse, score, misses};
  endfunction

  function automatic logic [OBS_W-1:0] expv();
    return {exp_led, exp_hit, exp_miss, SCORE_W'(exp_score), MISS_W'(exp_misses)};
  endfunction

  // Advance one clock; return at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; level = 2'd0; spawn = '0; sw = '0;
    cyc(); cyc();
    rst_n = 1'b1; enable = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      spawn = NUM_LED'($urandom());
      sw    = NUM_LED'($urandom());
      #1;
      total++;
      if (obs() !== '0) begin
        bad++; $display("FAIL reset_outputs k=%0d: got %h want 0", k, obs());
      end
      cyc();
    end
    spawn = '0; sw = '0; rst_n = 1'b1;
    cyc();
    total++;
    if (obs() !== expv() || led !== '0) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
    spawn[0] = 1'b1;
    cyc();
    spawn = '0;
    total++;
    if (led[0] !== 1'b0) begin
      bad++; $display("FAIL spawn_edge_led0: got %b want 0", led[0]);
    end
    cyc();
    total++;
    if (led[0] !== 1'b1 || obs() !== expv()) begin
      bad++; $display("FAIL spawn_latency_led0: got %b want 1 (obs %h model %h)", led[0], obs(), expv());
    end
  endtask

  task automatic test_level0_expiry();
    int lit_cycles, miss_seen;
    bit done;
    do_reset();
    level = 2'd0;
    spawn[5] = 1'b1;
    cyc();
    spawn = '0;
    lit_cycles = 0; miss_seen = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL expiry_model c=%0d: got %h want %h", c, obs(), expv());
      end
      if (miss_pulse) miss_seen++;
      if (led[5]) lit_cycles++;
      else if (lit_cycles > 0) done = 1'b1;
    end
    total++;
    if (!done || lit_cycles < 28 || lit_cycles > 32) begin
      bad++; $display("FAIL expiry_duration: got %0d clocks (ended=%0d) want 28..32", lit_cycles, done);
    end
    total++;
    if (miss_seen !== 1 || misses !== MISS_W'(1) || score !== '0) begin
      bad++; $display("FAIL expiry_counts: pulses=%0d misses=%0d score=%0d want 1/1/0", miss_seen, misses, score);
    end
    // The slot is cooling for two full ticks after expiry; spawns are ignored.
    spawn[5] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cyc();
      total++;
      if (led[5] !== 1'b0 || miss_pulse !== 1'b0 || obs() !== expv()) begin
        bad++; $display("FAIL cool_ignores_spawn c=%0d: led5=%b got %h want %h", c, led[5], obs(), expv());
      end
    end
    spawn = '0;
  endtask

  task automatic test_hit_latency();
    int pulses;
    do_reset();
    level = 2'd0;
    spawn[2] = 1'b1;
    cyc();
    spawn = '0;
    for (int c = 0; c < 5; c++) cyc();
    sw[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      total++;
      if (k < 4 && (led[2] !== 1'b1 || hit_pulse !== 1'b0)) begin
        bad++; $display("FAIL hit_latency_pre k=%0d: led2=%b hit=%b want 1/0", k, led[2], hit_pulse);
      end else if (k == 4 && (led[2] !== 1'b0 || hit_pulse !== 1'b1 || score !== SCORE_W'(1))) begin
        bad++; $display("FAIL hit_latency_edge: led2=%b hit=%b score=%0d want 0/1/1", led[2], hit_pulse, score);
      end
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (hit_pulse) pulses++;
    end
    // Switch still held: a fresh spawn must stay lit and score nothing.
    spawn[2] = 1'b1;
    cyc();
    spawn = '0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (hit_pulse) pulses++;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL held_switch_model c=%0d: got %h want %h", c, obs(), expv());
      end
    end
    total++;
    if (pulses !== 0 || led[2] !== 1'b1 || score !== SCORE_W'(1)) begin
      bad++; $display("FAIL held_switch_no_rescore: pulses=%0d led2=%b score=%0d want 0/1/1", pulses, led[2], score);
    end
    sw = '0;
  endtask

  task automatic test_simultaneous();
    bit [NUM_LED-1:0] mask;
    int pulses;
    do_reset();
    mask = '0; mask[0] = 1'b1; mask[1] = 1'b1; mask[17] = 1'b1;
    spawn = mask;
    cyc();
    spawn = '0;
    sw = mask;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (hit_pulse) pulses++;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL simultaneous_model c=%0d: got %h want %h", c, obs(), expv());
      end
    end
    total++;
    if (pulses !== 1 || score !== SCORE_W'(3) || (led & mask) !== '0) begin
      bad++; $display("FAIL simultaneous_hits: pulses=%0d score=%0d led=%h want 1/3/0", pulses, score, led & mask);
    end
    sw = '0;
  endtask

  task automatic test_level_change();
    int lit_a, lit_b;
    bit done;
    do_reset();
    level = 2'd0;
    spawn[3] = 1'b1;
    cyc();
    spawn = '0;
    level = 2'd3;
    lit_a = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL level_a_model c=%0d: got %h want %h", c, obs(), expv());
      end
      if (led[3]) lit_a++;
      else if (lit_a > 0) done = 1'b1;
    end
    total++;
    if (!done || lit_a < 29 || lit_a > 32) begin
      bad++; $display("FAIL level_latched_old: got %0d clocks want 29..32", lit_a);
    end
    spawn[4] = 1'b1;
    cyc();
    spawn = '0;
    lit_b = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL level_b_model c=%0d: got %h want %h", c, obs(), expv());
      end
      if (led[4]) lit_b++;
      else if (lit_b > 0) done = 1'b1;
    end
    total++;
    if (!done || lit_b < 9 || lit_b > 12) begin
      bad++; $display("FAIL level_new_spawn: got %0d clocks want 9..12", lit_b);
    end
  endtask

  task automatic test_enable();
    bit [NUM_LED-1:0] mask;
    do_reset();
    mask = '0;
    for (int i = 6; i <= 10; i++) mask[i] = 1'b1;
    spawn = mask;
    cyc();
    spawn = '0;
    sw[10] = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    total++;
    if (score !== SCORE_W'(1) || led[9:6] !== 4'hF) begin
      bad++; $display("FAIL enable_setup: score=%0d led=%h want 1/F", score, led[9:6]);
    end
    enable = 1'b0;
    cyc();
    total++;
    if (led !== '0 || score !== SCORE_W'(1) || misses !== '0) begin
      bad++; $display("FAIL enable_drop: led=%h score=%0d misses=%0d want 0/1/0", led, score, misses);
    end
    for (int c = 0; c < 20; c++) begin
      cyc();
      total++;
      if (obs() !== expv() || hit_pulse || miss_pulse) begin
        bad++; $display("FAIL enable_hold c=%0d: got %h want %h", c, obs(), expv());
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      total++;
      if (led !== '0 || obs() !== expv()) begin
        bad++; $display("FAIL enable_resume c=%0d: got %h want %h", c, obs(), expv());
      end
    end
    sw = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    level = 2'd0;
    for (int r = 0; r < 232; r++) begin
      spawn = '1; sw = '0;
      cyc();
      spawn = '0; sw = '1;
      for (int c = 0; c < 12; c++) begin
        cyc();
        total++;
        if (obs() !== expv()) begin
          bad++; $display("FAIL score_sat_model r=%0d c=%0d: got %h want %h", r, c, obs(), expv());
        end
      end
      sw = '0;
    end
    total++;
    if (score !== SCORE_W'(SCORE_MAX)) begin
      bad++; $display("FAIL score_saturated: got %0d want %0d", score, SCORE_MAX);
    end
    level = 2'd3;
    for (int r = 0; r < 16; r++) begin
      spawn = '1;
      cyc();
      spawn = '0;
      for (int c = 0; c < 24; c++) begin
        cyc();
        total++;
        if (obs() !== expv()) begin
          bad++; $display("FAIL miss_sat_model r=%0d c=%0d: got %h want %h", r, c, obs(), expv());
        end
      end
    end
    total++;
    if (misses !== MISS_W'(MISS_MAX) || score !== SCORE_W'(SCORE_MAX)) begin
      bad++; $display("FAIL miss_saturated: misses=%0d score=%0d want %0d/%0d", misses, score, MISS_MAX, SCORE_MAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      spawn = NUM_LED'($urandom() & $urandom() & $urandom());
      sw    = sw ^ NUM_LED'($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 31) == 0) level = 2'($urandom_range(0, 3));
      if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== '0) begin
          bad++; $display("FAIL async_reset c=%0d: got %h want 0", c, obs());
        end
        cyc();
        rst_n = 1'b1;
      end
      cyc();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL random_model c=%0d: got %h want %h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_level0_expiry();
    test_hit_latency();
    test_simultaneous();
    test_level_change();
    test_enable();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
